down_timer: RTL and testbench

// Loadable WIDTH-bit down-counting timer: the counting-down complement to the

---
 rtl/down_timer.sv | 113 +++++++++++
 tb/tb_down_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with a one-cycle expiry pulse.
// Accepts a period over a valid/ready handshake, counts it down once per clk,
// and either returns to IDLE or reloads the period (auto-reload mode).
// abort cancels everything, and pause holds the count.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic             ar, ar_nxt;
    logic             expired_nxt;
    logic             accept;

    // abort masks ready so that a load arriving with it is dropped, not deferred.
    assign load_ready = (state == IDLE) && !abort;
    assign accept     = load_valid && load_ready;
    assign busy       = (state != IDLE);

    // State, count, reload and pulse registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            ar      <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            reload  <= reload_nxt;
            ar      <= ar_nxt;
            expired <= expired_nxt;
        end
    end

    // Next-state logic: abort first, then pause, then load/decrement.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        reload_nxt  = reload;
        ar_nxt      = ar;
        expired_nxt = 1'b0;
        if (abort) begin
            // Any pending pulse is dropped along with the count.
            state_nxt = IDLE;
            count_nxt = '0;
            ar_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (load_value != '0) begin
                            count_nxt  = load_value;
                            reload_nxt = load_value;
                            ar_nxt     = auto_reload;
                            state_nxt  = RUN;
                        end else begin
                            // A zero period expires immediately and never reloads.
                            expired_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (count > WIDTH'(1)) begin
                        count_nxt = count - WIDTH'(1);
                    end else if (count == WIDTH'(1)) begin
                        expired_nxt = 1'b1;
                        if (ar) begin
                            count_nxt = reload;
                        end else begin
                            count_nxt = '0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        // A zero count in RUN cannot occur; recover to IDLE.
                        state_nxt = IDLE;
                    end
                end
                PAUSED: begin
                    // Leaving pause spends one edge with the count held.
                    if (!pause) state_nxt = RUN;
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer: hand-derived per-cycle expectations are queued
// as stimulus is driven, observations are queued after each edge, and each
// scenario task compares the two queues.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_value = 8'd0;
    logic       auto_reload = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       expired;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       bsy;
        logic       ex;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];

    down_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the expected post-edge outputs, capture actual.
    task automatic cyc(input logic lv, input logic [7:0] val, input logic ar,
                       input logic ps, input logic ab,
                       input logic [7:0] ecnt, input logic ebsy, input logic eex);
        obs_t e, o;
        load_valid  = lv;
        load_value  = val;
        auto_reload = ar;
        pause       = ps;
        abort       = ab;
        e.cnt = ecnt; e.bsy = ebsy; e.ex = eex;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.cnt = count; o.bsy = busy; o.ex = expired;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e, o;
        int i = 0;
        #2;
        checks++;
        if ({count, busy, expired} !== 10'd0) begin
            failures++;
            $display("FAIL reset_init: got count=%0d busy=%b expired=%b, want 0/0/0", count, busy, expired);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got load_ready=%b, want 1", load_ready);
        end
        cyc(1, 8'd8, 0, 0, 0, 8'd8, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd7, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd6, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd5, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_run[%0d]: got count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                         i, o.cnt, o.bsy, o.ex, e.cnt, e.bsy, e.ex);
            end
            i++;
        end
        // Asynchronous reset in mid-cycle while count is 5.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, busy, expired} !== 10'd0) begin
            failures++;
            $display("FAIL reset_async: got count=%0d busy=%b expired=%b, want 0/0/0", count, busy, expired);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (load_ready !== 1'b1 || count !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got load_ready=%b count=%0d busy=%b, want 1/0/0", load_ready, count, busy);
        end
    endtask

    task automatic test_oneshot();
        obs_t e, o;
        int i = 0;
        cyc(1, 8'd4, 0, 0, 0, 8'd4, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd3, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd2, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL oneshot[%0d]: got count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                         i, o.cnt, o.bsy, o.ex, e.cnt, e.bsy, e.ex);
            end
            i++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_ready: got load_ready=%b, want 1", load_ready);
        end
    endtask

    task automatic test_periodic();
        obs_t e, o;
        int i = 0;
        cyc(1, 8'd3, 1, 0, 0, 8'd3, 1, 0);
        for (int r = 0; r < 2; r++) begin
            cyc(0, 8'd0, 0, 0, 0, 8'd2, 1, 0);
            cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
            cyc(0, 8'd0, 0, 0, 0, 8'd3, 1, 1);
        end
        cyc(0, 8'd0, 0, 0, 0, 8'd2, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
        // Abort on the terminal edge: the pulse must be suppressed.
        abort = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL periodic_abort_ready: got load_ready=%b, want 0", load_ready);
        end
        cyc(0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        // Periodic N=1 pulses every cycle.
        cyc(1, 8'd1, 1, 0, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 1);
        cyc(0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL periodic[%0d]: got count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                         i, o.cnt, o.bsy, o.ex, e.cnt, e.bsy, e.ex);
            end
            i++;
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        int i = 0;
        cyc(1, 8'd5, 0, 0, 0, 8'd5, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd4, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd3, 1, 0);
        cyc(0, 8'd0, 0, 1, 0, 8'd3, 1, 0);
        cyc(0, 8'd0, 0, 1, 0, 8'd3, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd3, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd2, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        // Pause on the count==1 edge defers the expiry.
        cyc(1, 8'd2, 0, 0, 0, 8'd2, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pause[%0d]: got count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                         i, o.cnt, o.bsy, o.ex, e.cnt, e.bsy, e.ex);
            end
            i++;
        end
    endtask

    task automatic test_edges();
        obs_t e, o;
        int i = 0;
        // Zero load with auto_reload set: single pulse, stays IDLE.
        cyc(1, 8'd0, 1, 0, 0, 8'd0, 0, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        // Load while busy is ignored.
        cyc(1, 8'd3, 0, 0, 0, 8'd3, 1, 0);
        cyc(1, 8'd9, 1, 0, 0, 8'd2, 1, 0);
        cyc(1, 8'd9, 1, 0, 0, 8'd1, 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL edges[%0d]: got count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                         i, o.cnt, o.bsy, o.ex, e.cnt, e.bsy, e.ex);
            end
            i++;
        end
        // Abort with a coincident load: not accepted.
        load_valid = 1'b1; load_value = 8'd7; abort = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL edges_abort_ready: got load_ready=%b, want 0", load_ready);
        end
        @(posedge clk); #1;
        load_valid = 1'b0; abort = 1'b0;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || expired !== 1'b0) begin
            failures++;
            $display("FAIL edges_abort_load: got count=%0d busy=%b expired=%b, want 0/0/0", count, busy, expired);
        end
    endtask

    task automatic test_width();
        obs_t e, o;
        int i = 0;
        cyc(1, 8'd255, 0, 0, 0, 8'd255, 1, 0);
        for (int k = 1; k < 255; k++)
            cyc(0, 8'd0, 0, 0, 0, 8'(255 - k), 1, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL width[%0d]: got count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                         i, o.cnt, o.bsy, o.ex, e.cnt, e.bsy, e.ex);
            end
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_edges();
        test_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
